// File: rtl/sauria_neg_pkg.sv
// Shared types and width helpers for the negligence-threshold controller
// and the zero_det_neg instances it drives.
package sauria_neg_pkg;

  localparam int NEG_TH_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EVAL  = 2'd2
  } neg_ctrl_state_t;

  function automatic int pc_width(input int n_pe);
    return $clog2(n_pe + 1);
  endfunction

  function automatic int acc_width(input int cnt_w, input int n_pe);
    return cnt_w + pc_width(n_pe);
  endfunction

endpackage

// File: rtl/zero_popcount.sv
// Combinational population count of the per-PE zero-detect flags.
module zero_popcount
  import sauria_neg_pkg::*;
#(
  parameter  int N_PE = 16,
  localparam int PC_W = pc_width(N_PE)
) (
  input  logic [N_PE-1:0] i_flags,
  output logic [PC_W-1:0] o_count
);

  logic [PC_W-1:0] ext [N_PE];

  for (genvar gi = 0; gi < N_PE; gi++) begin : g_ext
    assign ext[gi] = PC_W'(i_flags[gi]);
  end

  always_comb begin
    o_count = '0;
    for (int i = 0; i < N_PE; i++) begin
      o_count = o_count + ext[i];
    end
  end

endmodule

// File: rtl/neg_thres_ctrl.sv
// Adaptive negligence-threshold controller: counts zero detections per window
// of valid cycles and nudges the shared threshold to keep sparsity in a band.
module neg_thres_ctrl
  import sauria_neg_pkg::*;
#(
  parameter  int TH_W  = NEG_TH_W,
  parameter  int N_PE  = 16,
  parameter  int CNT_W = 16,
  localparam int PC_W  = pc_width(N_PE),
  localparam int ACC_W = acc_width(CNT_W, N_PE)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [N_PE-1:0]  i_zero_det,
  input  logic             i_cfg_wr,
  input  logic             i_cfg_mode,
  input  logic [TH_W-1:0]  i_cfg_thres,
  input  logic [TH_W-1:0]  i_cfg_thres_max,
  input  logic [CNT_W-1:0] i_cfg_win_len,
  input  logic [ACC_W-1:0] i_cfg_tgt_lo,
  input  logic [ACC_W-1:0] i_cfg_tgt_hi,
  output logic [TH_W-1:0]  o_thres,
  output logic             o_thres_upd,
  output logic [ACC_W-1:0] o_win_zeros,
  output logic             o_busy
);

  neg_ctrl_state_t  state_reg;
  logic             mode_reg;
  logic [TH_W-1:0]  thres_max_reg;
  logic [CNT_W-1:0] win_len_reg;
  logic [ACC_W-1:0] tgt_lo_reg;
  logic [ACC_W-1:0] tgt_hi_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [CNT_W-1:0] vcnt_reg;
  logic [TH_W-1:0]  thres_reg;
  logic             upd_reg;
  logic [ACC_W-1:0] win_zeros_reg;
  logic             busy_reg;

  logic [PC_W-1:0]  pc;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] win_last;
  logic             win_done;
  logic             single_win;
  logic             step_up;
  logic             step_dn;
  logic [TH_W-1:0]  cfg_start;

  zero_popcount #(.N_PE(N_PE)) u_popcount (
    .i_flags (i_zero_det),
    .o_count (pc)
  );

  // Accumulator saturates instead of wrapping.
  assign acc_sum  = {1'b0, acc_reg} + (ACC_W + 1)'(pc);
  assign acc_next = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];

  // A programmed window length of zero behaves as one.
  assign win_last   = (win_len_reg == '0) ? '0 : win_len_reg - CNT_W'(1);
  assign win_done   = (vcnt_reg == win_last);
  assign single_win = (win_len_reg <= CNT_W'(1));

  // Increment wins when the band is inverted (lo > hi).
  assign step_up = (acc_reg < tgt_lo_reg) && (thres_reg < thres_max_reg);
  assign step_dn = !step_up && (acc_reg > tgt_hi_reg) && (thres_reg != '0);

  assign cfg_start = (i_cfg_mode && (i_cfg_thres_max < i_cfg_thres)) ? i_cfg_thres_max
                                                                      : i_cfg_thres;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= IDLE;
      mode_reg      <= 1'b0;
      thres_max_reg <= '0;
      win_len_reg   <= '0;
      tgt_lo_reg    <= '0;
      tgt_hi_reg    <= '0;
      acc_reg       <= '0;
      vcnt_reg      <= '0;
      thres_reg     <= '0;
      upd_reg       <= 1'b0;
      win_zeros_reg <= '0;
      busy_reg      <= 1'b0;
    end else if (i_cfg_wr) begin
      mode_reg      <= i_cfg_mode;
      thres_max_reg <= i_cfg_thres_max;
      win_len_reg   <= i_cfg_win_len;
      tgt_lo_reg    <= i_cfg_tgt_lo;
      tgt_hi_reg    <= i_cfg_tgt_hi;
      thres_reg     <= cfg_start;
      acc_reg       <= '0;
      vcnt_reg      <= '0;
      upd_reg       <= 1'b0;
      if (i_cfg_mode && i_en) begin
        state_reg <= ACCUM;
        busy_reg  <= 1'b1;
      end else begin
        state_reg <= IDLE;
        busy_reg  <= 1'b0;
      end
    end else begin
      upd_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          acc_reg  <= '0;
          vcnt_reg <= '0;
          if (mode_reg && i_en) begin
            state_reg <= ACCUM;
            busy_reg  <= 1'b1;
          end
        end
        ACCUM: begin
          if (!i_en || !mode_reg) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            acc_reg   <= '0;
            vcnt_reg  <= '0;
          end else if (i_valid) begin
            acc_reg  <= acc_next;
            vcnt_reg <= vcnt_reg + CNT_W'(1);
            if (win_done) state_reg <= EVAL;
          end
        end
        EVAL: begin
          win_zeros_reg <= acc_reg;
          if (step_up) begin
            thres_reg <= thres_reg + TH_W'(1);
            upd_reg   <= 1'b1;
          end else if (step_dn) begin
            thres_reg <= thres_reg - TH_W'(1);
            upd_reg   <= 1'b1;
          end
          if (!i_en) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            acc_reg   <= '0;
            vcnt_reg  <= '0;
          end else if (i_valid) begin
            // The seed sample alone completes a one-sample window.
            acc_reg   <= ACC_W'(pc);
            vcnt_reg  <= CNT_W'(1);
            state_reg <= single_win ? EVAL : ACCUM;
          end else begin
            acc_reg   <= '0;
            vcnt_reg  <= '0;
            state_reg <= ACCUM;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign o_thres     = thres_reg;
  assign o_thres_upd = upd_reg;
  assign o_win_zeros = win_zeros_reg;
  assign o_busy      = busy_reg;

endmodule

// File: tb/tb_neg_thres_ctrl.sv
// Self-checking bench for neg_thres_ctrl: directed vector table, hand-written
// corner sequences, then randomized traffic against a window-queue model.
module tb_neg_thres_ctrl;

  localparam int TH_W  = 2;
  localparam int N_PE  = 16;
  localparam int CNT_W = 16;
  localparam int ACC_W = 21;
  localparam int ACC_MAX = (1 << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst, en, valid, wr, mode;
  logic [N_PE-1:0]  zd;
  logic [TH_W-1:0]  th, thmax;
  logic [CNT_W-1:0] win;
  logic [ACC_W-1:0] lo, hi;
  logic [TH_W-1:0]  o_thres;
  logic             o_thres_upd;
  logic [ACC_W-1:0] o_win_zeros;
  logic             o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  neg_thres_ctrl #(.TH_W(TH_W), .N_PE(N_PE), .CNT_W(CNT_W)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_en            (en),
    .i_valid         (valid),
    .i_zero_det      (zd),
    .i_cfg_wr        (wr),
    .i_cfg_mode      (mode),
    .i_cfg_thres     (th),
    .i_cfg_thres_max (thmax),
    .i_cfg_win_len   (win),
    .i_cfg_tgt_lo    (lo),
    .i_cfg_tgt_hi    (hi),
    .o_thres         (o_thres),
    .o_thres_upd     (o_thres_upd),
    .o_win_zeros     (o_win_zeros),
    .o_busy          (o_busy)
  );

  typedef struct {
    logic rst, en, wr, valid, mode;
    logic [N_PE-1:0]  zd;
    logic [TH_W-1:0]  th, thmax;
    logic [CNT_W-1:0] win;
    logic [ACC_W-1:0] lo, hi;
    int   e_th;
    int   e_upd;
    int   e_wz;
    int   e_busy;
  } vec_t;

  vec_t tbl[$];
  logic             c_mode;
  logic [TH_W-1:0]  c_th, c_max;
  logic [CNT_W-1:0] c_win;
  logic [ACC_W-1:0] c_lo, c_hi;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input bit verbose);
    @(posedge clk);
    #1;
    if (verbose)
      $display("t=%0t rst=%0b en=%0b wr=%0b v=%0b zd=%h -> thres=%0d upd=%0b wz=%0d busy=%0b",
               $time, rst, en, wr, valid, zd, o_thres, o_thres_upd, o_win_zeros, o_busy);
  endtask

  task automatic add(input logic r, input logic e, input logic w, input logic v,
                     input logic [N_PE-1:0] z, input int eth, input int eupd,
                     input int ewz, input int ebusy);
    vec_t x;
    x.rst = r; x.en = e; x.wr = w; x.valid = v; x.zd = z;
    x.mode = c_mode; x.th = c_th; x.thmax = c_max; x.win = c_win; x.lo = c_lo; x.hi = c_hi;
    x.e_th = eth; x.e_upd = eupd; x.e_wz = ewz; x.e_busy = ebusy;
    tbl.push_back(x);
  endtask

  task automatic check_all(input string tag, input int eth, input int eupd,
                           input int ewz, input int ebusy);
    check({tag, "_thres"}, int'(o_thres), eth);
    check({tag, "_upd"},   int'(o_thres_upd), eupd);
    check({tag, "_wz"},    int'(o_win_zeros), ewz);
    check({tag, "_busy"},  int'(o_busy), ebusy);
  endtask

  task automatic cyc(input logic e, input logic v, input logic [N_PE-1:0] z);
    rst = 1'b0; wr = 1'b0; en = e; valid = v; zd = z;
    tick(1'b1);
  endtask

  task automatic cfgw(input logic md, input int t, input int tm, input int w,
                      input int l, input int h);
    rst = 1'b0; wr = 1'b1; en = 1'b1; valid = 1'b0; zd = '0;
    mode = md; th = TH_W'(t); thmax = TH_W'(tm); win = CNT_W'(w);
    lo = ACC_W'(l); hi = ACC_W'(h);
    tick(1'b1);
    wr = 1'b0;
  endtask

  // Reference model: keeps the current window as a queue of per-cycle counts.
  int m_thres, m_upd, m_wz, m_sum;
  bit m_active, m_pend;
  int m_q[$];
  bit mc_mode;
  int mc_max, mc_win, mc_lo, mc_hi;

  task automatic m_take(input int pc);
    int eff;
    int s;
    eff = (mc_win == 0) ? 1 : mc_win;
    m_q.push_back(pc);
    if (m_q.size() >= eff) begin
      s = m_q.sum();
      m_sum = (s > ACC_MAX) ? ACC_MAX : s;
      m_q.delete();
      m_pend = 1'b1;
    end
  endtask

  task automatic model_step();
    int pc;
    pc = $countones(zd);
    if (rst) begin
      m_thres = 0; m_upd = 0; m_wz = 0; m_active = 0; m_pend = 0; m_q.delete();
      mc_mode = 0; mc_max = 0; mc_win = 0; mc_lo = 0; mc_hi = 0;
    end else if (wr) begin
      mc_mode = mode; mc_max = int'(thmax); mc_win = int'(win);
      mc_lo = int'(lo); mc_hi = int'(hi);
      m_thres = (mode && thmax < th) ? int'(thmax) : int'(th);
      m_upd = 0; m_q.delete(); m_pend = 0;
      m_active = mode && en;
    end else begin
      m_upd = 0;
      if (m_pend) begin
        m_pend = 0;
        m_wz = m_sum;
        if (m_sum < mc_lo && m_thres < mc_max) begin
          m_thres++; m_upd = 1;
        end else if (m_sum > mc_hi && m_thres > 0) begin
          m_thres--; m_upd = 1;
        end
        m_active = en;
        if (en && valid) m_take(pc);
      end else if (!m_active) begin
        m_active = mc_mode && en;
      end else if (!en || !mc_mode) begin
        m_active = 0;
        m_q.delete();
      end else if (valid) begin
        m_take(pc);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; valid = 1'b0; wr = 1'b0; mode = 1'b0; zd = '0;
    th = '0; thmax = '0; win = '0; lo = '0; hi = '0;

    // Fixed mode
    c_mode = 1'b0; c_th = 2; c_max = 0; c_win = 0; c_lo = 0; c_hi = 0;
    add(1, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    add(0, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    add(0, 1, 1, 0, 16'h0000, 2, 0, 0, 0);
    add(0, 1, 0, 1, 16'hFFFF, 2, 0, 0, 0);
    add(0, 1, 0, 1, 16'hFFFF, 2, 0, 0, 0);
    // Adaptive upward walk to the clamp
    c_mode = 1'b1; c_th = 0; c_max = 3; c_win = 4; c_lo = 20; c_hi = 40;
    add(0, 1, 1, 0, 16'h0000, 0, 0, 0, 1);
    for (int w = 0; w < 4; w++) begin
      for (int s = 0; s < 4; s++) add(0, 1, 0, 1, 16'h0000, (w > 3) ? 3 : w, 0, 0, 1);
      add(0, 1, 0, 0, 16'h0000, (w + 1 > 3) ? 3 : w + 1, (w < 3) ? 1 : 0, 0, 1);
    end
    // Dense window steps down
    c_th = 3;
    add(0, 1, 1, 0, 16'h0000, 3, 0, 0, 1);
    for (int s = 0; s < 4; s++) add(0, 1, 0, 1, 16'hFFFF, 3, 0, 0, 1);
    add(0, 1, 0, 0, 16'h0000, 2, 1, 64, 1);
    // Sum exactly lo: no step; EVAL sample seeds next window
    for (int s = 0; s < 4; s++) add(0, 1, 0, 1, 16'h001F, 2, 0, 64, 1);
    add(0, 1, 0, 1, 16'h001F, 2, 0, 20, 1);
    for (int s = 0; s < 3; s++) add(0, 1, 0, 1, 16'h0000, 2, 0, 20, 1);
    add(0, 1, 0, 0, 16'h0000, 3, 1, 5, 1);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; en = tbl[i].en; wr = tbl[i].wr; valid = tbl[i].valid; zd = tbl[i].zd;
      mode = tbl[i].mode; th = tbl[i].th; thmax = tbl[i].thmax; win = tbl[i].win;
      lo = tbl[i].lo; hi = tbl[i].hi;
      tick(1'b1);
      check_all($sformatf("tbl%0d", i), tbl[i].e_th, tbl[i].e_upd, tbl[i].e_wz, tbl[i].e_busy);
    end

    // Enable dropped mid-window: partial window discarded
    cfgw(1'b1, 1, 3, 4, 20, 40);
    check_all("en_cfg", 1, 0, 5, 1);
    cyc(1, 1, '0); cyc(1, 1, '0);
    cyc(0, 0, '0);
    check_all("en_low", 1, 0, 5, 0);
    cyc(0, 0, '0);
    cyc(1, 0, '0);
    check("en_rise_busy", int'(o_busy), 1);
    cyc(1, 1, '0); cyc(1, 1, '0); cyc(1, 1, '0);
    cyc(1, 0, '0);
    check_all("en_discard", 1, 0, 5, 1);
    cyc(1, 1, '0);
    cyc(1, 0, '0);
    check_all("en_fresh", 2, 1, 0, 1);

    // Config write during EVAL wins
    for (int s = 0; s < 4; s++) cyc(1, 1, '0);
    check("cfg_pre_thres", int'(o_thres), 2);
    cfgw(1'b1, 0, 3, 4, 20, 40);
    check_all("cfg_in_eval", 0, 0, 0, 1);
    for (int s = 0; s < 4; s++) cyc(1, 1, '0);
    cyc(1, 0, '0);
    check_all("post_cfg_up", 1, 1, 0, 1);
    for (int s = 0; s < 4; s++) cyc(1, 1, 16'h00FF);
    cyc(1, 0, '0);
    check_all("band_hold", 1, 0, 32, 1);

    // Synchronous reset mid-window
    cyc(1, 1, 16'hFFFF); cyc(1, 1, 16'hFFFF);
    rst = 1'b1; tick(1'b1);
    check_all("rst_mid", 0, 0, 0, 0);
    cyc(1, 1, 16'hFFFF);
    check_all("rst_cfg_cleared", 0, 0, 0, 0);

    // Randomized traffic against the model
    rst = 1'b1; wr = 1'b0; en = 1'b0; valid = 1'b0; zd = '0;
    model_step();
    tick(1'b0);
    check_all("rnd_rst", m_thres, m_upd, m_wz, int'(m_active || m_pend));
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 599) == 0);
      wr    = ($urandom_range(0, 39) == 0);
      mode  = ($urandom_range(0, 3) != 0);
      th    = TH_W'($urandom_range(0, 3));
      thmax = TH_W'($urandom_range(0, 3));
      win   = CNT_W'($urandom_range(0, 5));
      lo    = ACC_W'($urandom_range(0, 50));
      hi    = ACC_W'($urandom_range(0, 70));
      en    = ($urandom_range(0, 19) != 0);
      valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       zd = '0;
        1:       zd = '1;
        default: zd = N_PE'($urandom);
      endcase
      model_step();
      tick(1'b0);
      if (o_thres_upd) $display("t=%0t rnd step thres=%0d wz=%0d", $time, o_thres, o_win_zeros);
      check_all($sformatf("rnd%0d", n), m_thres, m_upd, m_wz, int'(m_active || m_pend));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/neg_thres_ctrl.md
# neg_thres_ctrl

Adaptive controller for the negligence threshold driven into every `zero_det_neg` instance of the systolic array. It counts zero/negligence detections reported by the PEs over a programmable window of valid compute cycles. At each window boundary it steps the shared threshold up or down to keep the observed sparsity inside a configured band. In fixed mode it simply registers the configured threshold. It sits beside the array control logic, fed by the config interface and the per-PE `o_zero_det` outputs.

## Interface
- `TH_W`, 2: threshold width; must match `zero_det_neg`.
- `N_PE`, 16: number of zero-detect flags sampled per cycle.
- `CNT_W`, 16: window length counter width.
- `PC_W`, $clog2(N_PE+1): popcount width (derived).
- `ACC_W`, CNT_W+PC_W: accumulator width (derived).
- `i_clk`  in  1  clock; one clock domain.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_en`  in  1  compute active; low forces IDLE.
- `i_valid`  in  1  `i_zero_det` sample is valid this cycle.
- `i_zero_det`  in  N_PE  per-PE zero/negligence flags.
- `i_cfg_wr`  in  1  single-cycle pulse; loads all `i_cfg_*`.
- `i_cfg_mode`  in  1  0 = fixed threshold, 1 = adaptive.
- `i_cfg_thres`  in  TH_W  fixed value, or adaptive start value.
- `i_cfg_thres_max`  in  TH_W  adaptive upper clamp.
- `i_cfg_win_len`  in  CNT_W  valid cycles per window; 0 is treated as 1.
- `i_cfg_tgt_lo`  in  ACC_W  lower bound of the target zero-count band.
- `i_cfg_tgt_hi`  in  ACC_W  upper bound of the target zero-count band.
- `o_thres`  out  TH_W  threshold to all PEs (`i_thres`).
- `o_thres_upd`  out  1  one-cycle pulse when `o_thres` changed by adaptation.
- `o_win_zeros`  out  ACC_W  zero count of the last completed window.
- `o_busy`  out  1  high when state is not IDLE.

## Operation
- Config is captured into internal registers on `i_cfg_wr`. Captured values are used until the next write.
- On `i_cfg_wr`, `o_thres` is loaded as follows:
  - fixed mode: `o_thres <= i_cfg_thres`.
  - adaptive mode: `o_thres <= min(i_cfg_thres, i_cfg_thres_max)`.
  - In both cases the accumulator and valid counter are cleared. `o_thres_upd` is not pulsed.
- States:
  - IDLE: entered on reset, on `i_en`=0, or in fixed mode. Accumulator and counter held at 0.
  - ACCUM: adaptive mode with `i_en`=1. Every cycle with `i_valid`=1: `acc += popcount(i_zero_det)` and `vcnt += 1`. When a valid sample arrives with `vcnt == win_len-1`, the FSM moves to EVAL; `acc` includes that sample.
  - EVAL: lasts one cycle.
    - `o_win_zeros <= acc`.
    - If `acc < tgt_lo` and `o_thres < thres_max`: `o_thres += 1`.
    - Else if `acc > tgt_hi` and `o_thres > 0`: `o_thres -= 1`.
    - Otherwise `o_thres` holds.
    - `o_thres_upd` is 1 next cycle only if `o_thres` changed.
    - A valid sample arriving in EVAL seeds the next window: `acc = popcount`, `vcnt = 1`. With no valid sample, both are set to 0. No samples are lost.
    - Next state is ACCUM, or IDLE if `i_en` is 0.
- Accumulator saturates at all-ones and never wraps.
- If `tgt_lo > tgt_hi`, the increment rule has priority.
- `i_en` falling mid-window: FSM goes to IDLE, the partial window is discarded, `o_thres` holds. On `i_en` rising, a fresh window starts.
- `i_cfg_wr` has priority over EVAL in the same cycle: the config load wins and no adaptation step is taken.

## Timing
- Reset values: `o_thres`=0 (negligence off), `o_thres_upd`=0, `o_win_zeros`=0, `o_busy`=0, state IDLE, captured config all 0.
- `o_thres` changes 1 cycle after `i_cfg_wr`.
- `o_thres` changes 1 cycle after the EVAL cycle.
- Latency from the last valid sample of a window to the new `o_thres`: 2 cycles.
- Popcount and accumulate are a single registered stage; there is no combinational path from `i_zero_det` to any output.
- `o_thres` changes only at window boundaries or on config writes. Downstream PEs see a stable threshold within a window.

## Structure
- Shared package `sauria_neg_pkg` holds:
  - the state enum `neg_ctrl_state_t` (IDLE, ACCUM, EVAL);
  - the derived width constants (`PC_W`, `ACC_W`) as functions of `N_PE`/`CNT_W`;
  - `TH_W` default constant shared with `zero_det_neg`.
- One sub-module, `zero_popcount`: combinational N_PE-bit popcount producing PC_W bits. It is instantiated once.

## Test plan
- Reset, then fixed mode with `i_cfg_thres`=2 and `i_cfg_wr` → `o_thres`=2 one cycle later; `o_busy`=0; `o_thres_upd` never pulses.
- Adaptive, start=0, max=3, win_len=4, lo=20, hi=40, four valid cycles with all N_PE=16 flags clear → `o_win_zeros`=0. `o_thres` steps 0→1→2→3 over three windows, then stays at 3 (clamp). One `o_thres_upd` pulse per step.
- Adaptive, start=3, every flag set over win_len=4 → acc=64 > hi → `o_thres`=2 two cycles after the 4th sample; `o_win_zeros`=64.
- Window of sum exactly 20 (=lo) → no change, no `o_thres_upd`. Valid sample during EVAL with 5 flags → next window starts with acc=5, vcnt=1.
- `i_en` dropped after 2 of 4 samples, then raised → first window discarded. The following window needs 4 fresh samples; `o_thres` unchanged meanwhile.
- `i_cfg_wr` in the EVAL cycle → config load wins with no adaptation step. Synchronous `i_rst` mid-ACCUM → all outputs at reset values next cycle.
